// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg -- shared definitions for the serial program loader.
//   ADDR_W_DEF / DATA_W_DEF / SYNC_BYTE_DEF : default parameter values
//   state_e   : loader FSM state encoding
//   is_busy() : true while a frame is being received
package prog_loader_pkg;

  localparam int unsigned ADDR_W_DEF    = 11;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_CNT_HI  = 4'd3,
    ST_CNT_LO  = 4'd4,
    ST_DATA    = 4'd5,
    ST_CHECK   = 4'd6,
    ST_RUN     = 4'd7,
    ST_ERROR   = 4'd8
  } state_e;

  function automatic logic is_busy(input state_e s);
    return s inside {ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_CHECK};
  endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// byte_assembler -- packs DATA_W/8 bytes (MSB first) into one word.
//   clk, reset  : clock, synchronous active-high reset (discards a partial word)
//   byte_valid  : byte_in is consumed this cycle
//   byte_in     : incoming byte
//   word        : last completed word (held until the next one completes)
//   word_valid  : one-cycle pulse, the cycle after the final byte of a word
module byte_assembler
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shifted;
  logic              last_byte;

  always_comb begin
    // Truncating cast keeps this valid for DATA_W == 8 as well.
    shifted      = DATA_W'({sr_q, byte_in});
    last_byte    = (cnt_q == CNT_W'(BYTES - 1));
    sr_d         = sr_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    cnt_d        = cnt_q;
    if (byte_valid) begin
      sr_d = shifted;
      if (last_byte) begin
        word_d       = shifted;
        word_valid_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sr_q         <= sr_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader -- receives a framed byte stream and writes it into instruction
// memory, then releases the CPU.
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT words (MSB first) [, CHK]
//   clk, reset     : clock, synchronous active-high reset
//   rx_data/valid  : incoming byte stream; rx_ready is high outside reset
//   w_instruction  : word to write, w_adrs : write address
//   w_enable       : one-cycle write strobe
//   cpu_en         : CPU run enable (only in RUN)
//   busy           : frame in progress, error : last frame rejected
// Build option: define PROG_LOADER_CHKSUM_EN to require the trailing XOR
// checksum byte; otherwise the frame ends at its last data word and error is 0.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] w_instruction,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic              cpu_en,
  output logic              busy,
  output logic              error
);

`ifdef PROG_LOADER_CHKSUM_EN
  localparam state_e END_ST = ST_CHECK;
`else
  localparam state_e END_ST = ST_RUN;
`endif

  state_e            state_q, state_d, st_eff;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [15:0]       cnt_full;
  logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif
  logic              accept;
  logic              final_wr;
  logic              asm_valid;
  logic              word_valid;

  assign rx_ready = ~reset;
  assign accept   = rx_valid & rx_ready;

  byte_assembler #(
    .DATA_W(DATA_W)
  ) u_byte_assembler (
    .clk       (clk),
    .reset     (reset),
    .byte_valid(asm_valid),
    .byte_in   (rx_data),
    .word      (w_instruction),
    .word_valid(word_valid)
  );

  always_comb begin
    // The final word's write cycle still belongs to DATA, but a byte arriving
    // in that same cycle is already the next field (CHK, or a new SYNC), so
    // it is decoded as if the FSM had already moved on.
    final_wr     = (state_q == ST_DATA) && word_valid && (words_left_q == 16'd1);
    st_eff       = final_wr ? END_ST : state_q;
    state_d      = st_eff;
    addr_hi_d    = addr_hi_q;
    cnt_hi_d     = cnt_hi_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    asm_valid    = 1'b0;
    cnt_full     = {cnt_hi_q, rx_data};
`ifdef PROG_LOADER_CHKSUM_EN
    chk_d        = chk_q;
`endif

    if (word_valid) begin
      addr_d       = addr_q + 1'b1;
      words_left_d = words_left_q - 16'd1;
    end

    if (accept) begin
      case (st_eff)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_ADDR_HI;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_d   = '0;
`endif
          end
        end
        ST_ADDR_HI: begin
          addr_hi_d = rx_data;
          state_d   = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d  = ADDR_W'({addr_hi_q, rx_data});
          state_d = ST_CNT_HI;
        end
        ST_CNT_HI: begin
          cnt_hi_d = rx_data;
          state_d  = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          words_left_d = cnt_full;
          state_d      = (cnt_full == 16'd0) ? END_ST : ST_DATA;
        end
        ST_DATA: begin
          asm_valid = 1'b1;
        end
`ifdef PROG_LOADER_CHKSUM_EN
        ST_CHECK: begin
          state_d = (rx_data == chk_q) ? ST_RUN : ST_ERROR;
        end
`endif
        default: ;
      endcase

`ifdef PROG_LOADER_CHKSUM_EN
      if (st_eff inside {ST_ADDR_HI, ST_ADDR_LO, ST_CNT_HI, ST_CNT_LO, ST_DATA})
        chk_d = chk_q ^ rx_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_hi_q    <= '0;
      cnt_hi_q     <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_hi_q    <= addr_hi_d;
      cnt_hi_q     <= cnt_hi_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign w_enable = word_valid;
  assign w_adrs   = addr_q;
  assign cpu_en   = (state_q == ST_RUN);
  assign busy     = is_busy(state_q);
`ifdef PROG_LOADER_CHKSUM_EN
  assign error    = (state_q == ST_ERROR);
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- self-checking bench for prog_loader (default parameters).
// Follows PROG_LOADER_CHKSUM_EN the same way as the design.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int          NVEC   = 8;
`ifdef PROG_LOADER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] w_instruction;
  logic              w_enable;
  logic [ADDR_W-1:0] w_adrs;
  logic              cpu_en;
  logic              busy;
  logic              error;

  int unsigned       checks = 0;
  int unsigned       errors = 0;
  int unsigned       wr_count = 0;
  logic [ADDR_W-1:0] last_wr_adrs = '0;

  typedef struct {
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef logic [7:0] byteq_t[$];

  typedef struct {
    logic [15:0]       addr;
    int unsigned       cnt;
    logic [DATA_W-1:0] first;
    bit                corrupt;
    int unsigned       gap;
    int unsigned       exp_writes;
    logic [ADDR_W-1:0] exp_last;
    bit                exp_cpu;
    bit                exp_err;
  } vec_t;
  vec_t tbl[NVEC];

  prog_loader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .w_instruction(w_instruction),
    .w_enable     (w_enable),
    .w_adrs       (w_adrs),
    .cpu_en       (cpu_en),
    .busy         (busy),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicted.
  always @(negedge clk) begin : write_monitor
    wr_t e;
    if (w_enable === 1'b1) begin
      wr_count++;
      last_wr_adrs = w_adrs;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adrs 0x%0h data 0x%0h, required no write",
                 w_adrs, w_instruction);
      end else begin
        e = exp_q.pop_front();
        check("write_adrs", 64'(w_adrs), 64'(e.adrs));
        check("write_data", 64'(w_instruction), 64'(e.data));
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // gap: 0 continuous, 1 one idle cycle after every byte, 2 random idles
  task automatic send_stream(input byteq_t s, input int unsigned gap);
    foreach (s[k]) begin
      if (gap == 2 && $urandom_range(0, 2) == 0) idle(1);
      drive_byte(s[k]);
      if (gap == 1) idle(1);
    end
  endtask

  task automatic build_frame(input logic [15:0] a, input int unsigned cnt,
                             input logic [DATA_W-1:0] first, input bit corrupt,
                             inout byteq_t f);
    logic [15:0]       c16;
    logic [7:0]        x;
    logic [DATA_W-1:0] wd;
    c16 = 16'(cnt);
    f.push_back(SYNC);
    f.push_back(a[15:8]);
    f.push_back(a[7:0]);
    f.push_back(c16[15:8]);
    f.push_back(c16[7:0]);
    x = a[15:8] ^ a[7:0] ^ c16[15:8] ^ c16[7:0];
    for (int w = 0; w < int'(cnt); w++) begin
      wd = (w == 0) ? first : DATA_W'($urandom);
      for (int b = int'(NBYTES) - 1; b >= 0; b--) begin
        f.push_back(wd[8*b +: 8]);
        x = x ^ wd[8*b +: 8];
      end
    end
    if (CHK_EN) f.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  // Reference: parse the byte stream frame by frame, queue the writes it must
  // produce and track whether the CPU ends up enabled or the frame rejected.
  task automatic model_stream(input byteq_t s, inout bit run, inout bit err);
    int                i;
    logic [15:0]       a16;
    logic [15:0]       c16;
    logic [7:0]        x;
    logic [DATA_W-1:0] wd;
    wr_t               e;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      run = 1'b0;
      err = 1'b0;
      a16 = {s[i+1], s[i+2]};
      c16 = {s[i+3], s[i+4]};
      x   = s[i+1] ^ s[i+2] ^ s[i+3] ^ s[i+4];
      i   = i + 5;
      for (int w = 0; w < int'(c16); w++) begin
        wd = '0;
        for (int b = 0; b < int'(NBYTES); b++) begin
          wd = (wd << 8) | DATA_W'(s[i]);
          x  = x ^ s[i];
          i++;
        end
        e.adrs = ADDR_W'((int'(a16) + w) % (1 << ADDR_W));
        e.data = wd;
        exp_q.push_back(e);
      end
      if (CHK_EN) begin
        if (s[i] == x) run = 1'b1;
        else           err = 1'b1;
        i++;
      end else begin
        run = 1'b1;
      end
    end
  endtask

  initial begin
    bit          run;
    bit          err;
    byteq_t      f;
    int unsigned wr0;
    logic [15:0] ra;
    logic [7:0]  junk;

    tbl[0] = '{16'h0001, 1, 32'hDEADBEEF, 1'b0, 0, 1, 11'h001, 1'b1, 1'b0};
    tbl[1] = '{16'h07FF, 2, 32'hA5A500A5, 1'b0, 0, 2, 11'h000, 1'b1, 1'b0};
    tbl[2] = '{16'h0123, 3, 32'h0BADF00D, 1'b1, 0, 3, 11'h125, !CHK_EN, CHK_EN};
    tbl[3] = '{16'h0010, 1, 32'h00000001, 1'b0, 0, 1, 11'h010, 1'b1, 1'b0};
    tbl[4] = '{16'h0200, 2, 32'h12345678, 1'b0, 1, 2, 11'h201, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFE, 3, 32'hCAFEF00D, 1'b0, 1, 3, 11'h000, 1'b1, 1'b0};
    tbl[6] = '{16'h0055, 0, 32'h00000000, 1'b0, 1, 0, 11'h000, 1'b1, 1'b0};
    tbl[7] = '{16'hA5A5, 1, 32'hA5A5A5A5, 1'b1, 2, 1, 11'h5A5, !CHK_EN, CHK_EN};

    run      = 1'b0;
    err      = 1'b0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_rx_ready", 64'(rx_ready), 64'd0);
    check("reset_w_enable", 64'(w_enable), 64'd0);
    check("reset_w_adrs", 64'(w_adrs), 64'd0);
    check("reset_w_instruction", 64'(w_instruction), 64'd0);
    check("reset_cpu_en", 64'(cpu_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rx_ready_after_reset", 64'(rx_ready), 64'd1);

    // Single word FFFF0000 at address 1, exact strobe timing.
    f.delete();
    build_frame(16'h0001, 1, 32'hFFFF0000, 1'b0, f);
    model_stream(f, run, err);
    for (int k = 0; k < 9; k++) drive_byte(f[k]);
    check("first_write_strobe", 64'(w_enable), 64'd1);
    check("first_write_adrs", 64'(w_adrs), 64'h1);
    check("first_write_data", 64'(w_instruction), 64'hFFFF0000);
    check("cpu_en_during_write", 64'(cpu_en), 64'd0);
    if (CHK_EN) drive_byte(f[9]);
    else        idle(1);
    check("strobe_one_cycle", 64'(w_enable), 64'd0);
    check("cpu_en_after_frame", 64'(cpu_en), 64'd1);
    check("busy_after_frame", 64'(busy), 64'd0);
    check("error_after_frame", 64'(error), 64'd0);

    // New SYNC while running drops cpu_en; finish it as a count-0 frame.
    f.delete();
    build_frame(16'h0000, 0, '0, 1'b0, f);
    model_stream(f, run, err);
    wr0 = wr_count;
    drive_byte(f[0]);
    check("resync_cpu_en_drop", 64'(cpu_en), 64'd0);
    check("resync_busy", 64'(busy), 64'd1);
    for (int k = 1; k < f.size(); k++) drive_byte(f[k]);
    idle(2);
    check("count0_cpu_en", 64'(cpu_en), 64'd1);
    check("count0_busy", 64'(busy), 64'd0);
    check("count0_no_write", 64'(wr_count - wr0), 64'd0);

    // Reset after two of four data bytes: no write, everything back to reset.
    f.delete();
    build_frame(16'h0020, 1, 32'h11223344, 1'b0, f);
    wr0 = wr_count;
    for (int k = 0; k < 7; k++) drive_byte(f[k]);
    reset = 1'b1;
    @(negedge clk);
    check("abort_rx_ready", 64'(rx_ready), 64'd0);
    check("abort_w_enable", 64'(w_enable), 64'd0);
    check("abort_w_adrs", 64'(w_adrs), 64'd0);
    check("abort_w_instruction", 64'(w_instruction), 64'd0);
    check("abort_cpu_en", 64'(cpu_en), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_error", 64'(error), 64'd0);
    reset = 1'b0;
    idle(4);
    check("abort_no_write", 64'(wr_count - wr0), 64'd0);
    check("abort_idle_busy", 64'(busy), 64'd0);
    run = 1'b0;
    err = 1'b0;

    for (int r = 0; r < NVEC; r++) begin
      f.delete();
      build_frame(tbl[r].addr, tbl[r].cnt, tbl[r].first, tbl[r].corrupt, f);
      model_stream(f, run, err);
      wr0 = wr_count;
      send_stream(f, tbl[r].gap);
      idle(3);
      check($sformatf("vec%0d_cpu_en", r), 64'(cpu_en), 64'(tbl[r].exp_cpu));
      check($sformatf("vec%0d_error", r), 64'(error), 64'(tbl[r].exp_err));
      check($sformatf("vec%0d_busy", r), 64'(busy), 64'd0);
      check($sformatf("vec%0d_writes", r), 64'(wr_count - wr0), 64'(tbl[r].exp_writes));
      if (tbl[r].exp_writes != 0)
        check($sformatf("vec%0d_last_adrs", r), 64'(last_wr_adrs), 64'(tbl[r].exp_last));
    end

    for (int n = 0; n < 24; n++) begin
      f.delete();
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = junk ^ 8'h01;
        f.push_back(junk);
      end
      ra = 16'($urandom);
      build_frame(ra, $urandom_range(0, 4), DATA_W'($urandom), ($urandom_range(0, 3) == 0), f);
      model_stream(f, run, err);
      send_stream(f, 2);
      idle(3);
      check($sformatf("rand%0d_cpu_en", n), 64'(cpu_en), 64'(run));
      check($sformatf("rand%0d_error", n), 64'(error), 64'(err));
      check($sformatf("rand%0d_busy", n), 64'(busy), 64'd0);
    end

    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
